// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Multi-cycle ALU that sits between the A/B operand registers and the Z
// register pair. The control unit starts an operation with a start/done
// handshake. Logic, add/sub, negate and the barrel shifts/rotates finish in
// one cycle. Signed multiply (radix-2 Booth) and signed divide (restoring
// division on magnitudes, then a sign fix-up) iterate for WIDTH cycles.
//
// Build option:
//   SEQ_ALU_DIV_EN - when defined, the divider is built and opcode 0011
//                    performs a signed divide. When undefined, no divider
//                    logic exists and 0011 is reported as an illegal opcode.
//
// Parameters:
//   WIDTH    operand/result width (power of two, >= 4)
//   SHAMT_W  shift amount width, taken from b[SHAMT_W-1:0]
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset; also aborts a running op
//   start        operation request, only looked at while idle
//   op           4-bit opcode, captured with start
//   a, b         operands, captured with start
//   busy         high while an operation is running or completing
//   done         one-cycle pulse when z_lo/z_hi and the flags are valid
//   z_lo, z_hi   result low/high words (LO/HI for MUL and DIV); held until
//                the next done
//   div_by_zero  valid with done; DIV with b == 0
//   illegal_op   valid with done; unused or compiled-out opcode
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NEG  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_SHRA = 4'b1100;
    localparam logic [3:0] OP_ADD  = 4'b1101;

    localparam logic [WIDTH-1:0] COUNT_INIT = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] COUNT_STEP = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration registers shared by the multiplier and the divider.
    // MUL: hi = Booth accumulator (one guard bit), lo = multiplier, q_m1 = Booth bit.
    // DIV: hi = partial remainder, lo = dividend shifting into quotient.
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic             q_m1;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] count;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             step_qm1;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;

    logic [WIDTH-1:0]   single_lo;
    logic               single_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;
    logic               iterative_op;

`ifdef SEQ_ALU_DIV_EN
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Ops that need the RUN state. DIV by zero never iterates: its result is known at once.
`ifdef SEQ_ALU_DIV_EN
    assign iterative_op = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
    assign iterative_op = (op == OP_MUL);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always lasts one cycle so done is a single pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = iterative_op ? RUN : DONE;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One-cycle results, computed directly from the live operands while idle.
    // Rotates use a doubled copy of a so the wrapped-around bits fall into place.
    always_comb begin
        single_lo      = '0;
        single_illegal = 1'b0;
        shamt          = b[SHAMT_W-1:0];
        rot_l          = {a, a} << shamt;
        rot_r          = {a, a} >> shamt;
        case (op)
            OP_ADD:  single_lo = a + b;
            OP_SUB:  single_lo = a - b;
            OP_SHL:  single_lo = a << shamt;
            OP_SHR:  single_lo = a >> shamt;
            OP_ROL:  single_lo = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR:  single_lo = rot_r[WIDTH-1:0];
            OP_AND:  single_lo = a & b;
            OP_OR:   single_lo = a | b;
            OP_NEG:  single_lo = -b;
            OP_NOT:  single_lo = ~b;
            OP_SHRA: single_lo = $signed(a) >>> shamt;
            default: single_illegal = 1'b1;
        endcase
    end

    // One iteration step. Booth adds or subtracts the sign-extended
    // multiplicand, then arithmetic-shifts {hi, lo, q_m1} right. The extra
    // accumulator bit keeps most-negative x most-negative from overflowing.
    // The divider shifts the remainder left and keeps the trial subtraction
    // when it does not go negative.
    always_comb begin
        m_ext = {mcand[WIDTH-1], mcand};
        case ({lo[0], q_m1})
            2'b01:   booth_sum = hi + m_ext;
            2'b10:   booth_sum = hi - m_ext;
            default: booth_sum = hi;
        endcase
        step_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        step_lo  = {booth_sum[0], lo[WIDTH-1:1]};
        step_qm1 = lo[0];
`ifdef SEQ_ALU_DIV_EN
        r_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
        diff    = r_shift - {1'b0, mcand};
        if (is_div) begin
            step_qm1 = 1'b0;
            if (!diff[WIDTH]) begin
                step_hi = diff;
                step_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = r_shift;
                step_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

`ifdef SEQ_ALU_DIV_EN
    // Magnitudes feed the unsigned divider. The quotient is negated when the
    // operand signs differ. The remainder takes the dividend's sign.
    // most-negative / -1 wraps back to most-negative through this negation.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
    assign q_fix = neg_q ? -step_lo : step_lo;
    assign r_fix = neg_r ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
`endif

    // Datapath and result registers. Results and flags load on the edge that
    // enters DONE and hold until the next completion or clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            hi          <= '0;
            lo          <= '0;
            q_m1        <= 1'b0;
            mcand       <= '0;
            count       <= '0;
            z_lo        <= '0;
            z_hi        <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= COUNT_INIT;
                        if (op == OP_MUL) begin
                            hi    <= '0;
                            lo    <= b;
                            q_m1  <= 1'b0;
                            mcand <= a;
`ifdef SEQ_ALU_DIV_EN
                            is_div <= 1'b0;
`endif
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (op == OP_DIV) begin
                            if (b == '0) begin
                                z_lo        <= '1;
                                z_hi        <= a;
                                div_by_zero <= 1'b1;
                                illegal_op  <= 1'b0;
                            end else begin
                                hi     <= '0;
                                lo     <= abs_a;
                                q_m1   <= 1'b0;
                                mcand  <= abs_b;
                                is_div <= 1'b1;
                                neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                                neg_r  <= a[WIDTH-1];
                            end
                        end
`endif
                        else begin
                            z_lo        <= single_lo;
                            z_hi        <= '0;
                            div_by_zero <= 1'b0;
                            illegal_op  <= single_illegal;
                        end
                    end
                end
                RUN: begin
                    hi   <= step_hi;
                    lo   <= step_lo;
                    q_m1 <= step_qm1;
                    if (count == '0) begin
                        z_lo        <= step_lo;
                        z_hi        <= step_hi[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
                        if (is_div) begin
                            z_lo <= q_fix;
                            z_hi <= r_fix;
                        end
`endif
                    end else begin
                        count <= count - COUNT_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//
// Directed bench for seq_alu at WIDTH=32. A table of vectors covers the main
// opcodes. Each vector lists its operands, the hand-computed results and the
// latency in clocks from driving start to seeing done. Hand-written sequences
// cover start held high during a multiply, a clear that aborts a multiply,
// and recovery afterwards.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic        div_by_zero;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .z_lo        (z_lo),
        .z_hi        (z_hi),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    function automatic void add_vec(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                    input logic [31:0] elo, input logic [31:0] ehi,
                                    input logic edbz, input logic eill, input int elat);
        vec_t v;
        v.op  = o;
        v.a   = va;
        v.b   = vb;
        v.lo  = elo;
        v.hi  = ehi;
        v.dbz = edbz;
        v.ill = eill;
        v.lat = elat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one request and waits (bounded) for done; lat counts edges from
    // the drive point to the first sample where done is high.
    task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  output int lat);
        @(posedge clock);
        #1;
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        lat   = 0;
        do begin
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end while (done !== 1'b1 && lat < 100);
    endtask

    task automatic check_output(input vec_t v, input int lat, input string tag);
        check({tag, ".latency"}, 64'(lat), 64'(v.lat));
        check({tag, ".done"}, 64'(done), 64'(1'b1));
        check({tag, ".z_lo"}, 64'(z_lo), 64'(v.lo));
        check({tag, ".z_hi"}, 64'(z_hi), 64'(v.hi));
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(v.dbz));
        check({tag, ".illegal_op"}, 64'(illegal_op), 64'(v.ill));
        @(posedge clock);
        #1;
        check({tag, ".done_pulse"}, 64'(done), 64'(1'b0));
    endtask

    initial begin
        int   lat;
        int   ndone;
        vec_t v;

        clock = 1'b0;
        clear = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;

        //       op       a             b             z_lo          z_hi          dbz ill lat
        add_vec(4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 0, 0, 1);
        add_vec(4'b1101, 32'h00000005, 32'h00000007, 32'h0000000C, 32'h00000000, 0, 0, 1);
        add_vec(4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h00000000, 0, 0, 1);
        add_vec(4'b1100, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h00000000, 0, 0, 1);
        add_vec(4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 32'h00000000, 0, 0, 1);
        add_vec(4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h00000000, 0, 0, 1);
        add_vec(4'b0111, 32'h00000001, 32'h00000001, 32'h80000000, 32'h00000000, 0, 0, 1);
        add_vec(4'b0110, 32'h80000001, 32'h00000004, 32'h00000018, 32'h00000000, 0, 0, 1);
        add_vec(4'b0110, 32'h12345678, 32'h00000020, 32'h12345678, 32'h00000000, 0, 0, 1);
        add_vec(4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000, 0, 0, 1);
        add_vec(4'b1001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h00000000, 0, 0, 1);
        add_vec(4'b1010, 32'h00000000, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 0, 0, 1);
        add_vec(4'b1011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1);
        add_vec(4'b1110, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000000, 0, 1, 1);
        add_vec(4'b0000, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000000, 0, 1, 1);
        add_vec(4'b1111, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000000, 0, 1, 1);
        add_vec(4'b0010, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 33);
        add_vec(4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 0, 0, 33);
        add_vec(4'b0010, 32'h00000007, 32'h00000009, 32'h0000003F, 32'h00000000, 0, 0, 33);
        add_vec(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 33);
        add_vec(4'b0010, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000, 0, 0, 33);
`ifdef SEQ_ALU_DIV_EN
        add_vec(4'b0011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 33);
        add_vec(4'b0011, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1, 0, 1);
        add_vec(4'b0011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 0, 33);
        add_vec(4'b0011, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 0, 0, 33);
        add_vec(4'b0011, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 33);
        add_vec(4'b0011, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 0, 0, 33);
`else
        add_vec(4'b0011, 32'h00000007, 32'h00000002, 32'h00000000, 32'h00000000, 0, 1, 1);
        add_vec(4'b0011, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 0, 1, 1);
`endif

        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        check("reset.busy", 64'(busy), 64'(1'b0));
        check("reset.done", 64'(done), 64'(1'b0));
        check("reset.z_lo", 64'(z_lo), 64'h0);
        check("reset.z_hi", 64'(z_hi), 64'h0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'(1'b0));
        check("reset.illegal_op", 64'(illegal_op), 64'(1'b0));

        foreach (vecs[i]) begin
            v = vecs[i];
            apply_stimulus(v.op, v.a, v.b, lat);
            check_output(v, lat, $sformatf("vec%0d", i));
        end

        // start held high for the whole multiply: only the first request counts.
        @(posedge clock);
        #1;
        op    = 4'b0010;
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        lat   = 0;
        ndone = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (done === 1'b1) ndone++;
            op = 4'b1101;
            a  = 32'd1;
            b  = 32'd1;
        end while (done !== 1'b1 && lat < 100);
        start = 1'b0;
        check("hold.latency", 64'(lat), 64'd33);
        check("hold.z_lo", 64'(z_lo), 64'd63);
        check("hold.z_hi", 64'(z_hi), 64'd0);
        repeat (5) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("hold.done_count", 64'(ndone), 64'd1);
        check("hold.busy_after", 64'(busy), 64'(1'b0));
        apply_stimulus(4'b1101, 32'd1, 32'd1, lat);
        check("hold.next_latency", 64'(lat), 64'd1);
        check("hold.next_z_lo", 64'(z_lo), 64'd2);
        @(posedge clock);
        #1;

        // clear in the middle of a multiply aborts it without a done pulse.
        @(posedge clock);
        #1;
        op    = 4'b0010;
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        ndone = 0;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("abort.busy_before", 64'(busy), 64'(1'b1));
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("abort.busy", 64'(busy), 64'(1'b0));
        check("abort.done", 64'(done), 64'(1'b0));
        check("abort.z_lo", 64'(z_lo), 64'h0);
        check("abort.z_hi", 64'(z_hi), 64'h0);
        check("abort.illegal_op", 64'(illegal_op), 64'(1'b0));
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("abort.no_done", 64'(ndone), 64'd0);

        // Recovery after the abort.
        apply_stimulus(4'b0010, 32'hFFFFFFFD, 32'd7, lat);
        check("recover.latency", 64'(lat), 64'd33);
        check("recover.product", {z_hi, z_lo}, 64'hFFFFFFFF_FFFFFFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
